// File: rtl/otp_sequencer_pkg.sv
// Shared constants and state encoding for the one-time-pad sequencer.
//   MSG_SIZE  : plaintext / pad / cyphertext width
//   KEY_SIZE  : width of one key block fed to the cypher per cycle
//   NBLK      : number of key blocks per message
//   BLK_CNT_W : width of the key-block down-counter
//   state_t   : sequencer FSM states
package otp_sequencer_pkg;

    localparam int MSG_SIZE  = 32;
    localparam int KEY_SIZE  = 8;
    localparam int NBLK      = MSG_SIZE / KEY_SIZE;
    localparam int BLK_CNT_W = $clog2(NBLK + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SKEW  = 3'd2,
        ST_KEY   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

endpackage

// File: rtl/otp_block_mux.sv
// Combinational selector of one KEY_SIZE block out of the pad register.
// Block 0 is the most significant block of the pad.
//   pad : full-length pad register
//   idx : block index k (0..NBLK-1)
//   blk : pad[MSG_SIZE-1-k*KEY_SIZE -: KEY_SIZE]; zero for an out-of-range index
module otp_block_mux
    import otp_sequencer_pkg::*;
(
    input  logic [MSG_SIZE-1:0]  pad,
    input  logic [BLK_CNT_W-1:0] idx,
    output logic [KEY_SIZE-1:0]  blk
);

    always_comb begin
        blk = '0;
        for (int i = 0; i < NBLK; i++) begin
            if (idx == BLK_CNT_W'(i)) begin
                blk = pad[MSG_SIZE-1-i*KEY_SIZE -: KEY_SIZE];
            end
        end
    end

endmodule

// File: rtl/otp_sequencer.sv
// Control stage in front of the cypher. Accepts a message and a one-time pad,
// pulses the cypher load, streams the pad MSB block first on the key input,
// captures the cypher output after a fixed drain and hands it downstream.
// Flags an accepted pad that equals the previously accepted one.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake; in_msg / in_pad payload
//   cy_load/cy_msg/cy_key : drive the cypher; cy_out is its result bus
//   out_valid/out_ready   : downstream handshake; out_data is the cyphertext
//   busy                  : high whenever not IDLE
//   err_pad_reuse         : one-cycle advisory flag after a repeated pad
module otp_sequencer
    import otp_sequencer_pkg::*;
#(
    parameter int KEY_SKEW = 1,
    parameter int DRAIN    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MSG_SIZE-1:0] in_msg,
    input  logic [MSG_SIZE-1:0] in_pad,
    output logic                cy_load,
    output logic [MSG_SIZE-1:0] cy_msg,
    output logic [KEY_SIZE-1:0] cy_key,
    input  logic [MSG_SIZE-1:0] cy_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MSG_SIZE-1:0] out_data,
    output logic                busy,
    output logic                err_pad_reuse
);

    if (MSG_SIZE % KEY_SIZE != 0) begin : g_bad_msg_size
        $error("otp_sequencer: MSG_SIZE must be a multiple of KEY_SIZE");
    end
    if (KEY_SKEW < 1) begin : g_bad_key_skew
        $error("otp_sequencer: KEY_SKEW must be at least 1");
    end
    if (DRAIN < 1) begin : g_bad_drain
        $error("otp_sequencer: DRAIN must be at least 1");
    end

    // One timer serves both SKEW and DRAIN, so size it for the longer one.
    localparam int TMAX = (KEY_SKEW > DRAIN) ? KEY_SKEW : DRAIN;
    localparam int TW   = $clog2(TMAX + 1);

    state_t                 state, state_n;
    logic [BLK_CNT_W-1:0]   blk_cnt, blk_cnt_n;
    logic [TW-1:0]          tmr, tmr_n;
    logic [MSG_SIZE-1:0]    pad_reg;
    logic                   hist_vld;
    logic                   accept;
    logic                   capture;
    logic [BLK_CNT_W-1:0]   blk_idx;
    logic [KEY_SIZE-1:0]    pad_blk;

    // blk_cnt counts down from NBLK, so the MSB-first block index is NBLK - blk_cnt.
    assign blk_idx = BLK_CNT_W'(NBLK) - blk_cnt;

    otp_block_mux u_block_mux (
        .pad (pad_reg),
        .idx (blk_idx),
        .blk (pad_blk)
    );

    // Next-state logic
    always_comb begin
        state_n   = state;
        blk_cnt_n = blk_cnt;
        tmr_n     = tmr;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (KEY_SKEW > 1) begin
                    state_n = ST_SKEW;
                    tmr_n   = TW'(KEY_SKEW - 1);
                end else begin
                    state_n   = ST_KEY;
                    blk_cnt_n = BLK_CNT_W'(NBLK);
                end
            end
            ST_SKEW: begin
                if (tmr == TW'(1)) begin
                    state_n   = ST_KEY;
                    blk_cnt_n = BLK_CNT_W'(NBLK);
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            ST_KEY: begin
                blk_cnt_n = blk_cnt - BLK_CNT_W'(1);
                if (blk_cnt == BLK_CNT_W'(1)) begin
                    state_n = ST_DRAIN;
                    tmr_n   = TW'(DRAIN);
                end
            end
            ST_DRAIN: begin
                if (tmr == TW'(1)) begin
                    capture = 1'b1;
                    state_n = ST_HOLD;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            blk_cnt       <= '0;
            tmr           <= '0;
            cy_msg        <= '0;
            pad_reg       <= '0;
            hist_vld      <= 1'b0;
            err_pad_reuse <= 1'b0;
            out_data      <= '0;
        end else begin
            state         <= state_n;
            blk_cnt       <= blk_cnt_n;
            tmr           <= tmr_n;
            err_pad_reuse <= accept && hist_vld && (in_pad == pad_reg);
            if (accept) begin
                cy_msg   <= in_msg;
                pad_reg  <= in_pad;
                hist_vld <= 1'b1;
            end
            if (capture) begin
                out_data <= cy_out;
            end
        end
    end

    // in_ready is held low while reset is asserted, whatever the state.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign cy_load   = (state == ST_LOAD);
    assign cy_key    = (state == ST_KEY) ? pad_blk : '0;
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_otp_sequencer.sv
// Bench for otp_sequencer with a behavioural XOR cypher on the cy_* bus.
module tb_otp_sequencer;
    import otp_sequencer_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [MSG_SIZE-1:0] in_msg = '0;
    logic [MSG_SIZE-1:0] in_pad = '0;
    logic                cy_load;
    logic [MSG_SIZE-1:0] cy_msg;
    logic [KEY_SIZE-1:0] cy_key;
    logic [MSG_SIZE-1:0] cy_out;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [MSG_SIZE-1:0] out_data;
    logic                busy;
    logic                err_pad_reuse;

    int n_tests = 0;
    int n_fail  = 0;
    logic [MSG_SIZE-1:0] exp_q[$];

    otp_sequencer #(.KEY_SKEW(1), .DRAIN(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_msg        (in_msg),
        .in_pad        (in_pad),
        .cy_load       (cy_load),
        .cy_msg        (cy_msg),
        .cy_key        (cy_key),
        .cy_out        (cy_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .err_pad_reuse (err_pad_reuse)
    );

    always #5 clk = ~clk;

    // Behavioural cypher: latch msg on load, then shift in NBLK key blocks
    // starting the cycle after load; output is msg XOR assembled key.
    logic [MSG_SIZE-1:0] cm_msg;
    logic [MSG_SIZE-1:0] cm_key;
    int                  cm_cnt;
    always @(posedge clk) begin
        if (rst) begin
            cm_msg <= '0;
            cm_key <= '0;
            cm_cnt <= NBLK;
        end else if (cy_load) begin
            cm_msg <= cy_msg;
            cm_key <= '0;
            cm_cnt <= 0;
        end else if (cm_cnt < NBLK) begin
            cm_key <= {cm_key[MSG_SIZE-KEY_SIZE-1:0], cy_key};
            cm_cnt <= cm_cnt + 1;
        end
    end
    assign cy_out = cm_msg ^ cm_key;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_tests++;
        if ({cy_load, out_valid, busy, err_pad_reuse} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {cy_load, out_valid, busy, err_pad_reuse});
        end
        n_tests++;
        if (cy_key !== '0) begin n_fail++; $display("FAIL reset_cy_key got=%h exp=0", cy_key); end
        n_tests++;
        if (cy_msg !== '0) begin n_fail++; $display("FAIL reset_cy_msg got=%h exp=0", cy_msg); end
        n_tests++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_basic();
        logic [MSG_SIZE-1:0] m = 32'hDEADBEEF;
        logic [MSG_SIZE-1:0] p = 32'h0F0F0F0F;
        logic [MSG_SIZE-1:0] e;
        logic [KEY_SIZE-1:0] ek;
        @(negedge clk);
        in_valid = 1'b1; in_msg = m; in_pad = p; out_ready = 1'b1;
        exp_q.push_back(32'hD1A2B1E0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            ek = (c >= 2 && c <= 5) ? p[MSG_SIZE-1-(c-2)*KEY_SIZE -: KEY_SIZE] : '0;
            n_tests++;
            if (cy_load !== 1'(c == 1)) begin n_fail++; $display("FAIL basic_cy_load c=%0d got=%b", c, cy_load); end
            n_tests++;
            if (cy_key !== ek) begin n_fail++; $display("FAIL basic_cy_key c=%0d got=%h exp=%h", c, cy_key, ek); end
            n_tests++;
            if (out_valid !== 1'(c == 8)) begin n_fail++; $display("FAIL basic_out_valid c=%0d got=%b exp=%b", c, out_valid, (c == 8)); end
            if (c == 1) begin
                n_tests++;
                if (cy_msg !== m) begin n_fail++; $display("FAIL basic_cy_msg got=%h exp=%h", cy_msg, m); end
            end
            if (c == 8) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_scoreboard_empty got=%h", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL basic_out_data got=%h exp=%h", out_data, e); end
                end
            end
        end
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_back_idle in_ready=%b busy=%b exp=1/0", in_ready, busy); end
    endtask

    task automatic test_block_order();
        logic [MSG_SIZE-1:0] m = 32'hCAFEBABE;
        logic [MSG_SIZE-1:0] e;
        logic [KEY_SIZE-1:0] seq [NBLK] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [KEY_SIZE-1:0] ek;
        @(negedge clk);
        in_valid = 1'b1; in_msg = m; in_pad = 32'h11223344; out_ready = 1'b1;
        exp_q.push_back(m ^ 32'h11223344);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            ek = (c >= 2 && c <= 5) ? seq[c-2] : '0;
            n_tests++;
            if (cy_key !== ek) begin n_fail++; $display("FAIL order_cy_key c=%0d got=%h exp=%h", c, cy_key, ek); end
            if (c == 8) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL order_scoreboard_empty got=%h", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e || out_valid !== 1'b1) begin
                        n_fail++; $display("FAIL order_out got=%h/%b exp=%h/1", out_data, out_valid, e);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [MSG_SIZE-1:0] m = 32'h0BADCAFE;
        logic [MSG_SIZE-1:0] p = 32'h77665544;
        logic [MSG_SIZE-1:0] e = '0;
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1; in_msg = m; in_pad = p; out_ready = 1'b0;
        exp_q.push_back(m ^ p);
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_timeout got=%b exp=1", out_valid); end
        if (exp_q.size() > 0) e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                n_fail++; $display("FAIL bp_hold i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, e);
            end
            n_tests++;
            if (in_ready !== 1'b0 || cy_msg !== m || err_pad_reuse !== 1'b0) begin
                n_fail++; $display("FAIL bp_ignore i=%0d in_ready=%b cy_msg=%h err=%b exp=0/%h/0", i, in_ready, cy_msg, err_pad_reuse, m);
            end
            // A second request during HOLD must be ignored.
            in_valid = 1'b1; in_msg = 32'h12345678; in_pad = p;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp=0/1/0", out_valid, in_ready, busy);
        end
        n_tests++;
        if (cy_msg !== m) begin n_fail++; $display("FAIL bp_cy_msg_kept got=%h exp=%h", cy_msg, m); end
    endtask

    task automatic test_pad_reuse();
        logic [MSG_SIZE-1:0] msgs [3] = '{32'h00000001, 32'h00000002, 32'h00000003};
        logic [MSG_SIZE-1:0] pads [3] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A};
        logic [MSG_SIZE-1:0] e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_msg = msgs[k]; in_pad = pads[k]; out_ready = 1'b1;
            exp_q.push_back(msgs[k] ^ pads[k]);
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                if (c == 1) in_valid = 1'b0;
                n_tests++;
                if (err_pad_reuse !== 1'(k == 1 && c == 1)) begin
                    n_fail++; $display("FAIL reuse_flag msg=%0d c=%0d got=%b exp=%b", k, c, err_pad_reuse, (k == 1 && c == 1));
                end
                if (c == 8) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin n_fail++; $display("FAIL reuse_scoreboard_empty got=%h", out_data); end
                    else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin n_fail++; $display("FAIL reuse_out_data msg=%0d got=%h exp=%h", k, out_data, e); end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_key();
        logic [MSG_SIZE-1:0] p = 32'h13572468;
        logic [MSG_SIZE-1:0] m2 = 32'h600DF00D;
        logic [MSG_SIZE-1:0] e;
        @(negedge clk);
        in_valid = 1'b1; in_msg = 32'hFFFF0000; in_pad = p; out_ready = 1'b1;
        exp_q.push_back(32'hFFFF0000 ^ p);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
        end
        n_tests++;
        if (cy_key !== 8'h24) begin n_fail++; $display("FAIL rst_mid_block2 got=%h exp=24", cy_key); end
        rst = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        n_tests++;
        if ({cy_load, out_valid, busy, err_pad_reuse, in_ready} !== 5'b00000) begin
            n_fail++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {cy_load, out_valid, busy, err_pad_reuse, in_ready});
        end
        n_tests++;
        if (cy_key !== '0 || cy_msg !== '0 || out_data !== '0) begin
            n_fail++; $display("FAIL rst_mid_data key=%h msg=%h out=%h exp=0", cy_key, cy_msg, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1; in_msg = m2; in_pad = p;
        exp_q.push_back(m2 ^ p);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            if (c == 1) begin
                n_tests++;
                if (err_pad_reuse !== 1'b0) begin n_fail++; $display("FAIL rst_hist_cleared got=%b exp=0", err_pad_reuse); end
            end
            if (c == 8) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rst_scoreboard_empty got=%h", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL rst_after_out_data got=%h exp=%h", out_data, e); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [MSG_SIZE-1:0] msgs [3] = '{32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        logic [MSG_SIZE-1:0] pads [3] = '{32'h1111EEEE, 32'h2222DDDD, 32'h3333CCCC};
        logic [MSG_SIZE-1:0] e;
        int idx = 0;
        int nout = 0;
        int last_acc = -1;
        int cyc = 0;
        bit acc_pend = 1'b0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_msg = msgs[0]; in_pad = pads[0];
        while (nout < 3 && cyc < 60) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_msg ^ in_pad);
                if (last_acc >= 0) begin
                    n_tests++;
                    if (cyc - last_acc !== 9) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=9", cyc - last_acc); end
                end
                last_acc = cyc;
                acc_pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (acc_pend) begin
                acc_pend = 1'b0;
                idx++;
                if (idx < 3) begin in_msg = msgs[idx]; in_pad = pads[idx]; end
                else in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_scoreboard_empty got=%h", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL b2b_out_data n=%0d got=%h exp=%h", nout, out_data, e); end
                end
                nout++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (nout !== 3) begin n_fail++; $display("FAIL b2b_output_count got=%0d exp=3", nout); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_block_order();
        test_backpressure();
        test_pad_reuse();
        test_reset_mid_key();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
